// File: rtl/dma_ctrl_rr_arb_if.sv
// Bundle between NB_PORTS core control ports and one merged DMA control port.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface dma_ctrl_rr_arb_if #(
    parameter int NB_PORTS   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int ID_W     = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;

    logic [NB_PORTS-1:0]                 slv_req_i;
    logic [NB_PORTS-1:0][ADDR_WIDTH-1:0] slv_add_i;
    logic [NB_PORTS-1:0]                 slv_wen_i;
    logic [NB_PORTS-1:0][DATA_WIDTH-1:0] slv_wdata_i;
    logic [NB_PORTS-1:0][BE_WIDTH-1:0]   slv_be_i;
    logic [NB_PORTS-1:0]                 slv_gnt_o;
    logic [NB_PORTS-1:0]                 slv_r_valid_o;
    logic [DATA_WIDTH-1:0]               slv_r_rdata_o;
    logic                                slv_r_opc_o;

    logic                                mst_req_o;
    logic [ADDR_WIDTH-1:0]               mst_add_o;
    logic                                mst_wen_o;
    logic [DATA_WIDTH-1:0]               mst_wdata_o;
    logic [BE_WIDTH-1:0]                 mst_be_o;
    logic [ID_W-1:0]                     mst_id_o;
    logic                                mst_gnt_i;
    logic                                mst_r_valid_i;
    logic [DATA_WIDTH-1:0]               mst_r_rdata_i;
    logic                                mst_r_opc_i;

    logic                                busy_o;
    logic                                err_o;

    modport slave (
        input  slv_req_i, slv_add_i, slv_wen_i, slv_wdata_i, slv_be_i,
        output slv_gnt_o, slv_r_valid_o, slv_r_rdata_o, slv_r_opc_o,
        output mst_req_o, mst_add_o, mst_wen_o, mst_wdata_o, mst_be_o, mst_id_o,
        input  mst_gnt_i, mst_r_valid_i, mst_r_rdata_i, mst_r_opc_i,
        output busy_o, err_o
    );

    modport master (
        output slv_req_i, slv_add_i, slv_wen_i, slv_wdata_i, slv_be_i,
        input  slv_gnt_o, slv_r_valid_o, slv_r_rdata_o, slv_r_opc_o,
        input  mst_req_o, mst_add_o, mst_wen_o, mst_wdata_o, mst_be_o, mst_id_o,
        output mst_gnt_i, mst_r_valid_i, mst_r_rdata_i, mst_r_opc_i,
        input  busy_o, err_o
    );
endinterface

// File: rtl/dma_ctrl_rr_arb.sv
// Round-robin merge of NB_PORTS control ports onto one DMA port; zero-latency grant and response routing.
// Backpressure: mst_gnt_i stalls the winner in place; MAX_OUTST unanswered requests block new requests.
module dma_ctrl_rr_arb #(
    parameter int NB_PORTS   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    dma_ctrl_rr_arb_if.slave   bus
);
    localparam int ID_W  = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NB_PORTS - 1);

    logic [ID_W-1:0]     rr_q;
    logic [ID_W-1:0]     win;
    logic                any_req;
    logic [CNT_W-1:0]    cnt_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [ID_W-1:0]     id_mem [MAX_OUTST];
    logic                err_q;
    logic                full;
    logic                empty;
    logic                mst_req;
    logic                hs;
    logic                pop;
    logic                stray_rsp;
    logic [NB_PORTS-1:0] gnt_vec;
    logic [NB_PORTS-1:0] rsp_vec;

    // Search upward from rr_q, wrapping past the last port.
    always_comb begin : p_arb
        int idx;
        idx     = 0;
        win     = rr_q;
        any_req = 1'b0;
        for (int k = 0; k < NB_PORTS; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NB_PORTS) begin
                idx = idx - NB_PORTS;
            end
            if (!any_req && bus.slv_req_i[ID_W'(idx)]) begin
                any_req = 1'b1;
                win     = ID_W'(idx);
            end
        end
    end

    assign full      = (cnt_q == CNT_FULL);
    assign empty     = (cnt_q == '0);
    assign mst_req   = any_req & ~full;
    assign hs        = mst_req & bus.mst_gnt_i;
    assign pop       = bus.mst_r_valid_i & ~empty;
    assign stray_rsp = bus.mst_r_valid_i & empty;

    always_comb begin
        gnt_vec                   = '0;
        rsp_vec                   = '0;
        gnt_vec[win]              = hs;
        rsp_vec[id_mem[rd_ptr_q]] = pop;
    end

    assign bus.mst_req_o     = mst_req;
    assign bus.mst_add_o     = bus.slv_add_i[win];
    assign bus.mst_wen_o     = bus.slv_wen_i[win];
    assign bus.mst_wdata_o   = bus.slv_wdata_i[win];
    assign bus.mst_be_o      = bus.slv_be_i[win];
    assign bus.mst_id_o      = win;
    assign bus.slv_gnt_o     = gnt_vec;
    assign bus.slv_r_valid_o = rsp_vec;
    assign bus.slv_r_rdata_o = bus.mst_r_rdata_i;
    assign bus.slv_r_opc_o   = bus.mst_r_opc_i;
    assign bus.busy_o        = ~empty;
    assign bus.err_o         = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q     <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (hs) begin
                rr_q     <= (win == ID_LAST) ? '0 : win + 1'b1;
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({hs, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            // A response with nothing outstanding is a protocol violation; latch it.
            if (stray_rsp) begin
                err_q <= 1'b1;
            end
        end
    end

    // ID storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk_i) begin
        if (hs) begin
            id_mem[wr_ptr_q] <= win;
        end
    end
endmodule

// File: tb/tb_dma_ctrl_rr_arb.sv
// Bench for dma_ctrl_rr_arb: directed vector table, corner sequences, then random traffic vs a queue model.
module tb_dma_ctrl_rr_arb;
    localparam int NP = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_ctrl_rr_arb_if #(.NB_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    dma_ctrl_rr_arb #(.NB_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: pointer, in-order queue of granted ports, sticky error.
    int m_rr;
    int m_q[$];
    bit m_err;

    logic [AW-1:0] l_add   [NP];
    logic [DW-1:0] l_wdata [NP];
    logic [BW-1:0] l_be    [NP];
    logic          l_wen   [NP];

    logic          obs_req;
    logic [NP-1:0] obs_gnt;
    logic [2:0]    obs_id;
    logic [NP-1:0] obs_rv;
    logic          obs_busy;
    logic          obs_err;
    logic [DW-1:0] obs_rdata;

    typedef struct {
        logic [NP-1:0] req;
        logic          gnt;
        logic          rv;
        logic [DW-1:0] rdata;
        logic          ereq;
        logic [NP-1:0] egnt;
        int            eid;
        logic [NP-1:0] erv;
        logic          ebusy;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner = requesting port with the smallest forward distance from the pointer.
    function automatic int model_winner(input logic [NP-1:0] req);
        int best  = -1;
        int bestd = NP;
        for (int p = 0; p < NP; p++) begin
            if (req[p]) begin
                int d = (p - m_rr + NP) % NP;
                if (d < bestd) begin
                    bestd = d;
                    best  = p;
                end
            end
        end
        return best;
    endfunction

    task automatic model_clear();
        m_rr  = 0;
        m_q.delete();
        m_err = 0;
    endtask

    // Called at posedge+1; drives one cycle, checks against the model, advances to next posedge+1.
    task automatic step(input logic [NP-1:0] req, input logic gnt, input logic rv,
                        input logic [DW-1:0] rdata, input logic opc);
        int            w;
        logic          exp_req;
        logic          hs;
        logic [NP-1:0] one;
        logic [NP-1:0] exp_gnt;
        logic [NP-1:0] exp_rv;
        one = 1;
        for (int p = 0; p < NP; p++) begin
            l_add[p]   = $urandom;
            l_wdata[p] = $urandom;
            l_be[p]    = BW'($urandom);
            l_wen[p]   = 1'($urandom);
            bus.slv_add_i[p]   = l_add[p];
            bus.slv_wdata_i[p] = l_wdata[p];
            bus.slv_be_i[p]    = l_be[p];
            bus.slv_wen_i[p]   = l_wen[p];
        end
        bus.slv_req_i     = req;
        bus.mst_gnt_i     = gnt;
        bus.mst_r_valid_i = rv;
        bus.mst_r_rdata_i = rdata;
        bus.mst_r_opc_i   = opc;
        #2;
        obs_req   = bus.mst_req_o;
        obs_gnt   = bus.slv_gnt_o;
        obs_id    = bus.mst_id_o;
        obs_rv    = bus.slv_r_valid_o;
        obs_busy  = bus.busy_o;
        obs_err   = bus.err_o;
        obs_rdata = bus.slv_r_rdata_o;

        w       = model_winner(req);
        exp_req = (w >= 0) && (m_q.size() < MO);
        hs      = exp_req && gnt;
        exp_gnt = hs ? (one << w) : '0;
        exp_rv  = (rv && m_q.size() > 0) ? (one << m_q[0]) : '0;

        chk("mst_req", obs_req, exp_req);
        if (exp_req) begin
            chk("mst_id", obs_id, w);
            chk("mst_add", bus.mst_add_o, l_add[w]);
            chk("mst_wdata", bus.mst_wdata_o, l_wdata[w]);
            chk("mst_be", bus.mst_be_o, l_be[w]);
            chk("mst_wen", bus.mst_wen_o, l_wen[w]);
        end
        chk("slv_gnt", obs_gnt, exp_gnt);
        chk("slv_r_valid", obs_rv, exp_rv);
        chk("r_rdata", obs_rdata, rdata);
        chk("r_opc", bus.slv_r_opc_o, opc);
        chk("busy", obs_busy, m_q.size() > 0);
        chk("err", obs_err, m_err);

        if (rv) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_err = 1;
        end
        if (hs) begin
            m_q.push_back(w);
            m_rr = (w + 1) % NP;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_err", bus.err_o, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        //            req    gnt   rv    rdata   ereq  egnt   eid erv    ebusy
        tbl[0]  = '{8'h24, 1'b1, 1'b0, 32'h0, 1'b1, 8'h04,  2, 8'h00, 1'b0};
        tbl[1]  = '{8'h24, 1'b1, 1'b0, 32'h0, 1'b1, 8'h20,  5, 8'h00, 1'b1};
        tbl[2]  = '{8'h00, 1'b0, 1'b1, 32'h1, 1'b0, 8'h00, -1, 8'h04, 1'b1};
        tbl[3]  = '{8'h00, 1'b0, 1'b1, 32'h2, 1'b0, 8'h00, -1, 8'h20, 1'b1};
        tbl[4]  = '{8'h08, 1'b1, 1'b0, 32'h0, 1'b1, 8'h08,  3, 8'h00, 1'b0};
        tbl[5]  = '{8'h01, 1'b1, 1'b0, 32'h0, 1'b1, 8'h01,  0, 8'h00, 1'b1};
        tbl[6]  = '{8'h40, 1'b1, 1'b0, 32'h0, 1'b1, 8'h40,  6, 8'h00, 1'b1};
        tbl[7]  = '{8'h00, 1'b0, 1'b1, 32'hA, 1'b0, 8'h00, -1, 8'h08, 1'b1};
        tbl[8]  = '{8'h00, 1'b0, 1'b1, 32'hB, 1'b0, 8'h00, -1, 8'h01, 1'b1};
        tbl[9]  = '{8'h00, 1'b0, 1'b1, 32'hC, 1'b0, 8'h00, -1, 8'h40, 1'b1};
        tbl[10] = '{8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, -1, 8'h00, 1'b0};
        tbl[11] = '{8'h81, 1'b0, 1'b0, 32'h0, 1'b1, 8'h00,  7, 8'h00, 1'b0};
        tbl[12] = '{8'h81, 1'b1, 1'b0, 32'h0, 1'b1, 8'h80,  7, 8'h00, 1'b0};
        tbl[13] = '{8'h81, 1'b1, 1'b0, 32'h0, 1'b1, 8'h01,  0, 8'h00, 1'b1};
        tbl[14] = '{8'h00, 1'b1, 1'b0, 32'h0, 1'b0, 8'h00, -1, 8'h00, 1'b1};
        tbl[15] = '{8'h00, 1'b0, 1'b1, 32'h3, 1'b0, 8'h00, -1, 8'h80, 1'b1};
        tbl[16] = '{8'h00, 1'b0, 1'b1, 32'h4, 1'b0, 8'h00, -1, 8'h01, 1'b1};

        model_clear();
        bus.slv_req_i     = '0;
        bus.slv_add_i     = '0;
        bus.slv_wen_i     = '0;
        bus.slv_wdata_i   = '0;
        bus.slv_be_i      = '0;
        bus.mst_gnt_i     = 1'b0;
        bus.mst_r_valid_i = 1'b0;
        bus.mst_r_rdata_i = '0;
        bus.mst_r_opc_i   = 1'b0;
        #2;
        chk("reset_busy", bus.busy_o, 1'b0);
        chk("reset_err", bus.err_o, 1'b0);
        chk("reset_mst_req", bus.mst_req_o, 1'b0);
        chk("reset_gnt", bus.slv_gnt_o, '0);
        chk("reset_rvalid", bus.slv_r_valid_o, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed table: two-port rotation, ordered response routing, stall, drop.
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, 1'b0);
            chk($sformatf("tbl%0d_req", i), obs_req, tbl[i].ereq);
            chk($sformatf("tbl%0d_gnt", i), obs_gnt, tbl[i].egnt);
            if (tbl[i].eid >= 0) chk($sformatf("tbl%0d_id", i), obs_id, tbl[i].eid);
            chk($sformatf("tbl%0d_rv", i), obs_rv, tbl[i].erv);
            chk($sformatf("tbl%0d_rdata", i), obs_rdata, tbl[i].rdata);
            chk($sformatf("tbl%0d_busy", i), obs_busy, tbl[i].ebusy);
        end

        // Fill to MAX_OUTST from a single port, then a pop must not release the request that cycle.
        for (int i = 0; i < MO; i++) begin
            step(8'h02, 1'b1, 1'b0, 32'h0, 1'b0);
            chk("fill_gnt", obs_gnt, 8'h02);
        end
        step(8'h02, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("full_req", obs_req, 1'b0);
        chk("full_busy", obs_busy, 1'b1);
        step(8'h02, 1'b1, 1'b1, 32'h5A, 1'b1);
        chk("full_pop_req", obs_req, 1'b0);
        chk("full_pop_rv", obs_rv, 8'h02);
        step(8'h02, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("resume_req", obs_req, 1'b1);
        chk("resume_gnt", obs_gnt, 8'h02);
        for (int i = 0; i < MO; i++) step(8'h00, 1'b0, 1'b1, 32'h0, 1'b0);

        // Stray response while empty: no routing, sticky error.
        step(8'h00, 1'b0, 1'b1, 32'h77, 1'b0);
        chk("stray_rv", obs_rv, 8'h00);
        step(8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("stray_err", obs_err, 1'b1);
        chk("stray_busy", obs_busy, 1'b0);
        step(8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("stray_err_hold", obs_err, 1'b1);

        // Three outstanding, then asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) step(8'hFF, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("pre_rst_busy", bus.busy_o, 1'b1);
        bus.slv_req_i = 8'h28;
        bus.mst_gnt_i = 1'b0;
        bus.mst_r_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_busy", bus.busy_o, 1'b0);
        chk("async_err", bus.err_o, 1'b0);
        chk("async_req", bus.mst_req_o, 1'b1);
        chk("async_id", bus.mst_id_o, 3);
        chk("async_rv", bus.slv_r_valid_o, '0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(8'h28, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("post_rst_gnt", obs_gnt, 8'h08);

        // All ports requesting with one response per cycle: strict rotation.
        do_reset();
        step(8'hFF, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("rot_gnt0", obs_gnt, 8'h01);
        for (int k = 1; k <= NP; k++) begin
            logic [NP-1:0] one;
            one = 1;
            step(8'hFF, 1'b1, 1'b1, DW'(k), 1'b0);
            chk($sformatf("rot_gnt%0d", k), obs_gnt, one << (k % NP));
        end
        for (int i = 0; i < 2; i++) step(8'h00, 1'b0, 1'b1, 32'h0, 1'b0);

        // Random traffic against the model, with periodic resets.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic rv;
            rv = ($urandom_range(0, 2) == 0);
            if (m_q.size() == 0 && $urandom_range(0, 15) != 0) rv = 1'b0;
            step(NP'($urandom), ($urandom_range(0, 3) != 0), rv, $urandom, 1'($urandom));
            if (n % 150 == 149) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dma_ctrl_rr_arb.md
DMA_CTRL_RR_ARB -- requirements
Module: dma_ctrl_rr_arb

Interface
REQ-001 The block SHALL have parameter NB_PORTS, default 8, giving the number of requesting core control ports.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, giving the control address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, giving the control data width; BE_WIDTH SHALL be DATA_WIDTH/8.
REQ-004 The block SHALL have parameter MAX_OUTST, default 4, giving the maximum number of granted-but-unanswered requests; ID_W SHALL be max(1,$clog2(NB_PORTS)).
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 slv_req_i / slv_add_i / slv_wen_i / slv_wdata_i / slv_be_i  in  [NB_PORTS] x 1/ADDR/1/DATA/BE  per-port request, address, wen (1=read), write data, byte enables.
REQ-008 slv_gnt_o  out  NB_PORTS  per-port grant.
REQ-009 slv_r_valid_o  out  NB_PORTS  per-port response strobe; slv_r_rdata_o  out  DATA  and slv_r_opc_o  out  1  are shared by all ports.
REQ-010 mst_req_o / mst_add_o / mst_wen_o / mst_wdata_o / mst_be_o / mst_id_o  out  1/ADDR/1/DATA/BE/ID_W  merged request toward the DMA control port; mst_id_o = winning port index.
REQ-011 mst_gnt_i  in  1  grant from DMA; mst_r_valid_i  in  1, mst_r_rdata_i  in  DATA, mst_r_opc_i  in  1  in-order response.
REQ-012 busy_o  out  1  high when outstanding count > 0; err_o  out  1  sticky protocol error.

Function
REQ-013 Arbitration SHALL be combinational round-robin: winner = first port with slv_req_i set, searching upward from pointer rr_q, wrapping at NB_PORTS-1 -> 0.
REQ-014 mst_req_o SHALL be 1 iff any slv_req_i is set and cnt_q < MAX_OUTST; mst_add/wen/wdata/be/id SHALL carry the winner's fields (don't-care when mst_req_o=0).
REQ-015 slv_gnt_o[winner] SHALL equal mst_req_o & mst_gnt_i; all other grant bits SHALL be 0 (zero-latency grant pass-through).
REQ-016 On handshake (mst_req_o & mst_gnt_i) rr_q SHALL become (winner+1) mod NB_PORTS at the next edge; without handshake rr_q SHALL hold, so a stalled winner keeps priority and its request fields stay presented.
REQ-017 On handshake the winner index SHALL be pushed into an ID FIFO of depth MAX_OUTST; on mst_r_valid_i the head SHALL be popped.
REQ-018 slv_r_valid_o[head] SHALL equal mst_r_valid_i in the same cycle (zero-latency response routing); slv_r_rdata_o/slv_r_opc_o SHALL equal mst_r_rdata_i/mst_r_opc_i.
REQ-019 cnt_q SHALL increment on push only, decrement on pop only, hold on simultaneous push and pop; FIFO pointers SHALL wrap modulo MAX_OUTST.
REQ-020 Full (cnt_q == MAX_OUTST): mst_req_o and all slv_gnt_o SHALL be 0; a pop in the same cycle SHALL NOT release the request until the next cycle.
REQ-021 Empty (cnt_q == 0) with mst_r_valid_i = 1: no slv_r_valid_o bit SHALL assert, cnt_q SHALL stay 0, err_o SHALL set and remain 1 until reset.
REQ-022 A request dropped before grant SHALL be legal; the arbiter SHALL simply re-evaluate the next cycle.

Reset
REQ-023 While rst_i = 1, rr_q, cnt_q, FIFO pointers and err_o SHALL be 0 asynchronously; busy_o = 0.
REQ-024 Outputs derived from inputs (mst_req_o, slv_gnt_o, slv_r_valid_o) SHALL follow REQ-014/015/018 against the reset state; reset mid-operation SHALL discard all outstanding IDs without generating responses.

Verification
REQ-025 Ports 2 and 5 request, mst_gnt_i=1, rr_q=0 -> cycle 0 gnt port 2, cycle 1 gnt port 5, mst_id_o = 2 then 5, rr_q = 6.
REQ-026 All 8 ports request continuously, mst_gnt_i=1, responses returned each cycle -> grants rotate 0..7,0 with no port granted twice in 8 handshakes.
REQ-027 MAX_OUTST=4, port 1 requests, mst_gnt_i=1, no responses -> 4 grants, then mst_req_o=0, busy_o=1; one r_valid -> slv_r_valid_o[1]=1, request resumes next cycle.
REQ-028 Grants to ports 3, 0, 6 then three r_valid pulses with rdata 0xA,0xB,0xC -> slv_r_valid_o routed to 3, 0, 6 in order with matching rdata; busy_o=0 afterwards.
REQ-029 mst_r_valid_i=1 with cnt_q=0 -> no slv_r_valid_o, err_o=1 held until rst_i.
REQ-030 rst_i asserted with cnt_q=3 mid-stream -> cnt_q=0, busy_o=0, rr_q=0 immediately; subsequent first grant goes to lowest requesting port.
